// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: owns the binary/Gray read pointer,
// synchronises the write Gray pointer and produces registered empty and fill level.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq_sync;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic          rd_en;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Handshake: ~rempty is the valid, rinc is the ready; an entry is consumed
  // only on a cycle where both are high. rinc while empty is silently ignored.
  always_comb begin
    wq_sync    = sync_q[SYNC_STAGES-1];
    wq_bin     = gray2bin(wq_sync);
    rd_en      = rinc & ~rempty;
    rbin_next  = rbin + PW'(rd_en);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Empty and level use the post-read pointer so a read on this edge is
  // reflected immediately; the stale write pointer only makes them pessimistic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
      rlevel    <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      rempty    <= (rgray_next == wq_sync);
      rlevel    <= wq_bin - rbin_next;
    end
  end

  assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic, compared every
// cycle against a count-based model of the read side and a delayed write count.
module tb_fifo_rd_ctrl;

  localparam int AW = 3;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rinc = 1'b0;
  logic [AW:0]   wptr_gray;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          rempty;
  logic [AW:0]   rlevel;

  // reference model state: plain counts of entries written/read, mod 16
  logic [AW:0] m_wcnt = '0;
  logic [AW:0] m_rcnt;
  logic [AW:0] m_wq [SS];
  logic        m_empty;
  logic [AW:0] m_level;
  logic [AW:0] prev_gray = '0;

  int n_checks = 0;
  int n_pass = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .rinc(rinc), .wptr_gray(wptr_gray),
    .raddr(raddr), .rptr_gray(rptr_gray), .rempty(rempty), .rlevel(rlevel)
  );

  always #5 clk = ~clk;

  assign wptr_gray = m_wcnt ^ (m_wcnt >> 1);

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rcnt  = '0;
      m_empty = 1'b1;
      m_level = '0;
      for (int i = 0; i < SS; i++) m_wq[i] = '0;
    end else begin
      logic [AW:0] seen;
      seen = m_wq[SS-1];
      if (rinc && !m_empty) m_rcnt = m_rcnt + 1'b1;
      m_empty = (m_rcnt == seen);
      m_level = seen - m_rcnt;
      for (int i = SS - 1; i > 0; i--) m_wq[i] = m_wq[i-1];
      m_wq[0] = m_wcnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic compare_all();
    logic [AW:0] occ;
    occ = m_wcnt - m_rcnt;
    check("raddr", 32'(raddr), 32'(m_rcnt[AW-1:0]));
    check("rptr_gray", 32'(rptr_gray), 32'(to_gray(m_rcnt)));
    check("rempty", 32'(rempty), 32'(m_empty));
    check("rlevel", 32'(rlevel), 32'(m_level));
    check("gray_one_bit", 32'($countones(rptr_gray ^ prev_gray) <= 1), 32'd1);
    check("no_over_report", 32'(rlevel <= occ), 32'd1);
    prev_gray = rptr_gray;
  endtask

  task automatic step(input logic rd);
    rinc = rd;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values();
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_rptr_gray", 32'(rptr_gray), 32'd0);
    check("rst_rlevel", 32'(rlevel), 32'd0);
    prev_gray = '0;
  endtask

  // reset pulsed between edges; write side clears from the same reset
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_wcnt = '0;
    #1 check_reset_values();
    rinc = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      m_wcnt = m_wcnt + 1'b1;
      step(1'b0);
    end
    for (int i = 0; i < SS + 1; i++) step(1'b0);
  endtask

  initial begin
    // 1: asynchronous reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    #6 rst_n = 1'b1;

    // 2: single write becomes visible after SYNC_STAGES+1 edges, then one read
    do_reset();
    m_wcnt = 4'd1;
    step(1'b0);
    check("t2_still_empty_e1", 32'(rempty), 32'd1);
    step(1'b0);
    step(1'b0);
    check("t2_rempty_e3", 32'(rempty), 32'd0);
    check("t2_rlevel_e3", 32'(rlevel), 32'd1);
    step(1'b1);
    check("t2_raddr", 32'(raddr), 32'd1);
    check("t2_gray", 32'(rptr_gray), 32'b0001);
    check("t2_empty", 32'(rempty), 32'd1);
    check("t2_level", 32'(rlevel), 32'd0);

    // 3: reads while empty are ignored
    for (int i = 0; i < 5; i++) step(1'b1);
    check("t3_raddr", 32'(raddr), 32'd1);
    check("t3_gray", 32'(rptr_gray), 32'b0001);
    check("t3_level", 32'(rlevel), 32'd0);

    // 4: full buffer then 8 back-to-back reads
    do_reset();
    write_n(8);
    check("t4_level_full", 32'(rlevel), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check("t4_raddr", 32'(raddr), 32'((i + 1) % 8));
    end
    check("t4_gray", 32'(rptr_gray), 32'b1100);
    check("t4_empty", 32'(rempty), 32'd1);

    // 5: wrap from rbin=14 across the pointer MSB
    write_n(6);
    for (int i = 0; i < 6; i++) step(1'b1);
    check("t5_rbin14_gray", 32'(rptr_gray), 32'(to_gray(4'd14)));
    write_n(4);
    check("t5_wrap_level", 32'(rlevel), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("t5_raddr", 32'(raddr), 32'd2);
    check("t5_gray", 32'(rptr_gray), 32'b0011);
    check("t5_empty", 32'(rempty), 32'd1);

    // 6: async reset while reading with level 5
    do_reset();
    write_n(5);
    check("t6_level5", 32'(rlevel), 32'd5);
    rinc = 1'b1;
    do_reset();

    // random traffic, occupancy never beyond 8
    for (int c = 0; c < 600; c++) begin
      logic [AW:0] occ;
      occ = m_wcnt - m_rcnt;
      if ($urandom_range(0, 2) != 0 && occ < 8) m_wcnt = m_wcnt + 1'b1;
      step(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
